sub_pipe: RTL
=============

SUB_PIPE -- requirements
Module: sub_pipe

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the operand and result width in bits (N >= 1).
REQ-002 The block SHALL have parameter CNTW, default 8, giving the borrow-counter width in bits.
REQ-003 Port CLK SHALL be an input of width 1: the single clock; all flops are rising-edge.
REQ-004 Port RESETN SHALL be an input of width 1: asynchronous, active-low reset.
REQ-005 Port IN_VALID SHALL be an input of width 1: the upstream operand pair is valid.
REQ-006 Port IN_READY SHALL be an output of width 1: the block accepts operands this cycle.
REQ-007 Ports I0 and I1 SHALL each be inputs of width N: the minuend and subtrahend, unsigned.
REQ-008 Port OUT_VALID SHALL be an output of width 1: the result is valid.
REQ-009 Port OUT_READY SHALL be an input of width 1: downstream accepts the result.
REQ-010 Port O SHALL be an output of width N: the difference.
REQ-011 Port BORROW SHALL be an output of width 1: I0 < I1 (unsigned) for the presented result.
REQ-012 Port BCOUNT SHALL be an output of width CNTW: the count of borrowing results delivered.
REQ-013 Port CLR SHALL be an input of width 1: synchronous clear of BCOUNT.

Function
REQ-014 The datapath SHALL be two register stages: S1 holds the operand pair plus v1, and S2 holds O, BORROW plus v2.
REQ-015 An input transfer SHALL occur when IN_VALID and IN_READY are both 1 at a rising edge.
REQ-016 An output transfer SHALL occur when OUT_VALID and OUT_READY are both 1 at a rising edge.
REQ-017 OUT_VALID SHALL equal v2.
REQ-018 S2 SHALL load when v2=0 or OUT_READY=1 (adv2); on load, v2 takes v1.
REQ-019 S1 SHALL load when v1=0 or adv2=1 (adv1); on load, v1 takes IN_VALID.
REQ-020 IN_READY SHALL equal adv1; the combinational ready path is permitted.
REQ-021 O SHALL be (S1.I0 + ~S1.I1 + 1) mod 2^N, i.e. two's-complement subtraction with carry-in 1.
REQ-022 BORROW SHALL be the inverted carry-out of that N-bit add.
REQ-023 Latency SHALL be exactly 2 cycles from input transfer to OUT_VALID=1 when OUT_READY stays 1.
REQ-024 Throughput SHALL be one transfer per cycle, with no bubbles under continuous valid and ready.
REQ-025 While OUT_VALID=1 and OUT_READY=0, O and BORROW SHALL hold stable.
REQ-026 With both stages full and OUT_READY=0, IN_READY SHALL be 0 and no data SHALL be lost or duplicated.
REQ-027 Operand values SHALL be ignored when IN_VALID=0; no bubble enters S2 as valid.
REQ-028 On each output transfer with BORROW=1, BCOUNT SHALL increment by 1.
REQ-029 BCOUNT SHALL saturate at 2^CNTW-1 and SHALL NOT wrap.
REQ-030 CLR=1 SHALL set BCOUNT to 0 at the next edge and SHALL take priority over a simultaneous increment.
REQ-031 CLR SHALL NOT affect the pipeline contents or the handshakes.

Reset
REQ-032 When RESETN=0, v1, v2, O, BORROW and BCOUNT SHALL go to 0 immediately, without waiting for CLK.
REQ-033 During reset, IN_READY SHALL be 1 (both stages empty) and OUT_VALID SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL discard all in-flight operands; no result SHALL appear after release.
REQ-035 The first input transfer SHALL be possible at the first rising edge with RESETN=1.

Verification (N=2, CNTW=8)
REQ-036 Reset then accept I0=3, I1=1 with OUT_READY=1 -> OUT_VALID=1 two cycles later with O=2, BORROW=0, BCOUNT=0.
REQ-037 Accept I0=1, I1=2 -> O=3, BORROW=1, and BCOUNT=1 after the output transfer; accept I0=0, I1=0 -> O=0, BORROW=0.
REQ-038 Stream four pairs (3,0),(2,1),(0,3),(1,1) back-to-back with OUT_READY=1 -> O=3,1,1,0 on consecutive cycles and BCOUNT=1.
REQ-039 Hold OUT_READY=0, offer 3 pairs -> two accepted, IN_READY=0 on the third, O held; raise OUT_READY -> results in order, none lost.
REQ-040 Preload BCOUNT to 255 via borrowing results, then one more borrow -> BCOUNT stays 255; CLR with a simultaneous borrow transfer -> BCOUNT=0.
REQ-041 Assert RESETN=0 with both stages full, between edges -> OUT_VALID=0 and BCOUNT=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage valid/ready unsigned subtractor with a borrow flag
// and a saturating, clearable count of borrowing results delivered.
module sub_pipe #(
    parameter int N    = 2,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [N-1:0]    I0,
    input  logic [N-1:0]    I1,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [N-1:0]    O,
    output logic            BORROW,
    output logic [CNTW-1:0] BCOUNT,
    input  logic            CLR
);
    logic [N-1:0]    a_q, b_q, o_q, o_d, nb;
    logic [N:0]      sum;
    logic            v1_q, v2_q, bw_q, bw_d, adv1, adv2;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        adv2  = !v2_q || OUT_READY;
        adv1  = !v1_q || adv2;
        nb    = ~b_q;
        sum   = (N+1)'(a_q) + (N+1)'(nb) + (N+1)'(1);
        o_d   = sum[N-1:0];
        bw_d  = ~sum[N];
        cnt_d = CLR ? '0
              : (v2_q && OUT_READY && bw_q && cnt_q != '1) ? cnt_q + {{(CNTW-1){1'b0}}, 1'b1}
              : cnt_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            a_q   <= '0;
            b_q   <= '0;
            v1_q  <= 1'b0;
            o_q   <= '0;
            bw_q  <= 1'b0;
            v2_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= IN_VALID;
                if (IN_VALID) begin
                    a_q <= I0;
                    b_q <= I1;
                end
            end
            // Result registers only move on real data so a bubble never disturbs them.
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    o_q  <= o_d;
                    bw_q <= bw_d;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign IN_READY  = adv1;
    assign OUT_VALID = v2_q;
    assign O         = o_q;
    assign BORROW    = bw_q;
    assign BCOUNT    = cnt_q;
endmodule
